airlock_cycle_ctrl: RTL and testbench

- Parametrised airlock sequencer that runs both arriving and departing cycles through one shared state machine.
- Provides per-direction wait times, a phase timeout with fault latching, and a door interlock.
- Drives the chamber pumps and door-open commands from the door and pressure sensors.
- Sits between the operator request logic and the airlock actuators.

---
 rtl/airlock_cycle_ctrl_pkg.sv | 39 +++
 rtl/airlock_cycle_ctrl_phase_timer.sv | 49 ++++
 rtl/airlock_cycle_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_airlock_cycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/airlock_cycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// airlock_pkg
// Shared types and defaults for the airlock cycle controller.
//   - state_e : 4-bit encoding of the sequencer states
//   - dir_e   : cycle direction (arrival / departure)
//   - DEF_*   : default counter width, wait lengths and phase timeout
//   - wait_cycles() : clamps a configured wait length to at least one cycle
// -----------------------------------------------------------------------------
package airlock_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_DEPART_WAIT = 5;
  localparam int DEF_ARRIVE_WAIT = 5;
  localparam int DEF_TIMEOUT     = 1000;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WAIT      = 4'd1,
    ST_EVAC      = 4'd2,
    ST_OPEN_OUT  = 4'd3,
    ST_CLOSE_OUT = 4'd4,
    ST_PRESS     = 4'd5,
    ST_OPEN_IN   = 4'd6,
    ST_CLOSE_IN  = 4'd7,
    ST_FAULT     = 4'd8
  } state_e;

  typedef enum logic {
    DIR_ARR = 1'b0,
    DIR_DEP = 1'b1
  } dir_e;

  // A zero-length wait would make WAIT unreachable as a real state, so the
  // shortest wait is one cycle.
  function automatic int wait_cycles(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/airlock_cycle_ctrl_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Saturating up-counter that measures how many cycles the controller has
// spent in its current state, compared against a load value.
//   clk       in  clock
//   rst       in  asynchronous active-high reset (count -> 0)
//   restart_i in  state entry: count restarts at 1 (the first cycle in state)
//   en_i      in  count enable; when low the count holds
//   load_i    in  cycle count at which done_o asserts
//   done_o    out count >= load_i
// Because the count is 1 in the first cycle after entry, done_o is high in
// the N-th cycle of a state and the owner leaves on the following edge, i.e.
// exactly N edges after the entry edge.
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CNT_W'(1);
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      // Saturate at all-ones so a long stay never wraps back below the load.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q >= load_i);

endmodule

// File: rtl/airlock_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// airlock_cycle_ctrl
// Airlock sequencer running arrival and departure cycles through one FSM:
//   IDLE -> WAIT -> EVAC -> OPEN_OUT -> CLOSE_OUT -> PRESS -> (DEP) IDLE
//                                                          -> (ARR) OPEN_IN
//                                                             -> CLOSE_IN -> IDLE
// Any timed phase that overruns TIMEOUT, or both doors sensed open outside
// IDLE, lands in FAULT until fault_clr.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   arrive_req, depart_req   single-cycle cycle requests
//   abort                    cancel, honoured only in WAIT
//   proceed                  craft has passed, close the open door
//   fault_clr                FAULT -> IDLE
//   pressurized, evacuated   chamber pressure sensors
//   inner_open, outer_open   door sensors
//   arriving, departing      active cycle direction
//   pump_evac, pump_press    pump commands
//   open_inner, open_outer   door-open commands
//   req_rej                  one-cycle pulse, request refused
//   cycle_done               one-cycle pulse, normal return to IDLE
//   fault                    block is in FAULT
//
// All outputs are registered from the next state, so they are valid in the
// first cycle after the state-entry edge.
//
// Build option: define AIRLOCK_REQ_QUEUE_EN to add a one-deep pending-request
// register that holds the first request arriving while a cycle is running.
// -----------------------------------------------------------------------------
module airlock_cycle_ctrl
  import airlock_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEPART_WAIT = DEF_DEPART_WAIT,
  parameter int ARRIVE_WAIT = DEF_ARRIVE_WAIT,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int ARRIVE_PRIO = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic arrive_req,
  input  logic depart_req,
  input  logic abort,
  input  logic proceed,
  input  logic fault_clr,
  input  logic pressurized,
  input  logic evacuated,
  input  logic inner_open,
  input  logic outer_open,
  output logic arriving,
  output logic departing,
  output logic pump_evac,
  output logic pump_press,
  output logic open_inner,
  output logic open_outer,
  output logic req_rej,
  output logic cycle_done,
  output logic fault
);

  localparam logic [CNT_W-1:0] DEP_N = CNT_W'(wait_cycles(DEPART_WAIT));
  localparam logic [CNT_W-1:0] ARR_N = CNT_W'(wait_cycles(ARRIVE_WAIT));
  localparam logic [CNT_W-1:0] TMO_N = CNT_W'(TIMEOUT);

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  // Set once the door being opened has been sensed open in OPEN_OUT/OPEN_IN;
  // from then on the state only waits for proceed and is no longer timed.
  logic   opened_q, opened_d, opened;

  logic   req_rej_q, req_rej_d;
  logic   cycle_done_q, cycle_done_d;
  logic   arriving_q, arriving_d;
  logic   departing_q, departing_d;
  logic   pump_evac_q, pump_evac_d;
  logic   pump_press_q, pump_press_d;
  logic   open_inner_q, open_inner_d;
  logic   open_outer_q, open_outer_d;
  logic   fault_q, fault_d;

  logic   start_ok, any_req, both_req, busy;
  dir_e   req_dir;
  logic   timer_done, timer_en, timer_restart;
  logic [CNT_W-1:0] timer_load;

  logic   pend_valid_q;
  dir_e   pend_dir_q;
  logic   queue_rej;

  assign start_ok = pressurized && !inner_open && !outer_open;
  assign any_req  = arrive_req || depart_req;
  assign both_req = arrive_req && depart_req;
  assign req_dir  = both_req   ? ((ARRIVE_PRIO != 0) ? DIR_ARR : DIR_DEP)
                  : arrive_req ? DIR_ARR : DIR_DEP;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_FAULT);

  // ---------------------------------------------------------------------------
  // Shared phase timer: WAIT length in WAIT, timeout everywhere else.
  // ---------------------------------------------------------------------------
  assign timer_load    = (state_q == ST_WAIT)
                       ? ((dir_q == DIR_DEP) ? DEP_N : ARR_N)
                       : TMO_N;
  assign timer_restart = (state_d != state_q);
  assign timer_en      = !(((state_q == ST_OPEN_OUT) || (state_q == ST_OPEN_IN)) && opened_q);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (timer_restart),
    .en_i      (timer_en),
    .load_i    (timer_load),
    .done_o    (timer_done)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    opened       = opened_q;
    req_rej_d    = 1'b0;
    cycle_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // A held request has its one chance in the first IDLE cycle; any
          // fresh request in that same cycle loses to it.
          if (start_ok) begin
            state_d = ST_WAIT;
            dir_d   = pend_dir_q;
          end else begin
            req_rej_d = 1'b1;
          end
          if (any_req) begin
            req_rej_d = 1'b1;
          end
        end else if (any_req) begin
          if (start_ok) begin
            state_d = ST_WAIT;
            dir_d   = req_dir;
          end
          if (!start_ok || both_req) begin
            req_rej_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (timer_done) begin
          state_d = ST_EVAC;
        end
      end

      ST_EVAC: begin
        if (evacuated) begin
          state_d = ST_OPEN_OUT;
        end else if (timer_done) begin
          state_d = ST_FAULT;
        end
      end

      ST_OPEN_OUT: begin
        opened = opened_q || outer_open;
        if (opened && proceed) begin
          state_d = ST_CLOSE_OUT;
        end else if (!opened && timer_done) begin
          state_d = ST_FAULT;
        end
      end

      ST_CLOSE_OUT: begin
        if (!outer_open) begin
          state_d = ST_PRESS;
        end else if (timer_done) begin
          state_d = ST_FAULT;
        end
      end

      ST_PRESS: begin
        if (pressurized) begin
          if (dir_q == DIR_DEP) begin
            state_d      = ST_IDLE;
            cycle_done_d = 1'b1;
          end else begin
            state_d = ST_OPEN_IN;
          end
        end else if (timer_done) begin
          state_d = ST_FAULT;
        end
      end

      ST_OPEN_IN: begin
        opened = opened_q || inner_open;
        if (opened && proceed) begin
          state_d = ST_CLOSE_IN;
        end else if (!opened && timer_done) begin
          state_d = ST_FAULT;
        end
      end

      ST_CLOSE_IN: begin
        if (!inner_open) begin
          state_d      = ST_IDLE;
          cycle_done_d = 1'b1;
        end else if (timer_done) begin
          state_d = ST_FAULT;
        end
      end

      ST_FAULT: begin
        if (any_req) begin
          req_rej_d = 1'b1;
        end
        if (fault_clr) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Door interlock breach overrides every other transition, including a
    // fault_clr attempted while both doors still read open.
    if ((state_q != ST_IDLE) && inner_open && outer_open) begin
      state_d      = ST_FAULT;
      cycle_done_d = 1'b0;
    end

    opened_d = (state_d == state_q) ? opened : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Optional pending-request register
  // ---------------------------------------------------------------------------
`ifdef AIRLOCK_REQ_QUEUE_EN
  logic pend_valid_d;
  dir_e pend_dir_d;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    queue_rej    = 1'b0;
    // Consumed (accepted or refused) in the first IDLE cycle.
    if (state_q == ST_IDLE) begin
      pend_valid_d = 1'b0;
    end
    if (busy && any_req) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_dir_d   = req_dir;
        queue_rej    = both_req;
      end else begin
        queue_rej = 1'b1;
      end
    end
    if (state_d == ST_FAULT) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_ARR;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
    end
  end
`else
  // Requests during a running cycle are dropped silently.
  assign pend_valid_q = 1'b0;
  assign pend_dir_q   = DIR_ARR;
  assign queue_rej    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Moore outputs, computed from the next state and registered.
  // Door commands are masked by the opposite door sensor.
  // ---------------------------------------------------------------------------
  always_comb begin
    arriving_d   = (state_d != ST_IDLE) && (state_d != ST_FAULT) && (dir_d == DIR_ARR);
    departing_d  = (state_d != ST_IDLE) && (state_d != ST_FAULT) && (dir_d == DIR_DEP);
    pump_evac_d  = (state_d == ST_EVAC);
    pump_press_d = (state_d == ST_PRESS);
    open_outer_d = (state_d == ST_OPEN_OUT) && !opened_d && !inner_open;
    open_inner_d = (state_d == ST_OPEN_IN)  && !opened_d && !outer_open;
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_ARR;
      opened_q     <= 1'b0;
      req_rej_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      arriving_q   <= 1'b0;
      departing_q  <= 1'b0;
      pump_evac_q  <= 1'b0;
      pump_press_q <= 1'b0;
      open_inner_q <= 1'b0;
      open_outer_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      opened_q     <= opened_d;
      req_rej_q    <= req_rej_d || queue_rej;
      cycle_done_q <= cycle_done_d;
      arriving_q   <= arriving_d;
      departing_q  <= departing_d;
      pump_evac_q  <= pump_evac_d;
      pump_press_q <= pump_press_d;
      open_inner_q <= open_inner_d;
      open_outer_q <= open_outer_d;
      fault_q      <= fault_d;
    end
  end

  assign arriving   = arriving_q;
  assign departing  = departing_q;
  assign pump_evac  = pump_evac_q;
  assign pump_press = pump_press_q;
  assign open_inner = open_inner_q;
  assign open_outer = open_outer_q;
  assign req_rej    = req_rej_q;
  assign cycle_done = cycle_done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_airlock_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_airlock_cycle_ctrl
// Directed bench. Event outputs (req_rej, cycle_done, fault rising) are
// checked by a monitor against a queue of expected events pushed by the
// stimulus thread; level checks are made directly. DUT is built with
// DEPART_WAIT=5, ARRIVE_WAIT=3, TIMEOUT=20, ARRIVE_PRIO=1.
// -----------------------------------------------------------------------------
module tb_airlock_cycle_ctrl;

  localparam int EV_REJ   = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arrive_req = 1'b0, depart_req = 1'b0, abort = 1'b0, proceed = 1'b0, fault_clr = 1'b0;
  logic pressurized = 1'b1, evacuated = 1'b0, inner_open = 1'b0, outer_open = 1'b0;
  logic arriving, departing, pump_evac, pump_press, open_inner, open_outer;
  logic req_rej, cycle_done, fault;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic fault_prev = 1'b0;
  int both_cnt = 0;
  int dep_inner_cnt = 0;
  int n;

  airlock_cycle_ctrl #(
    .CNT_W       (16),
    .DEPART_WAIT (5),
    .ARRIVE_WAIT (3),
    .TIMEOUT     (20),
    .ARRIVE_PRIO (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arrive_req  (arrive_req),
    .depart_req  (depart_req),
    .abort       (abort),
    .proceed     (proceed),
    .fault_clr   (fault_clr),
    .pressurized (pressurized),
    .evacuated   (evacuated),
    .inner_open  (inner_open),
    .outer_open  (outer_open),
    .arriving    (arriving),
    .departing   (departing),
    .pump_evac   (pump_evac),
    .pump_press  (pump_press),
    .open_inner  (open_inner),
    .open_outer  (open_outer),
    .req_rej     (req_rej),
    .cycle_done  (cycle_done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  function automatic string ev_name(input int e);
    case (e)
      EV_REJ:   return "req_rej";
      EV_DONE:  return "cycle_done";
      EV_FAULT: return "fault";
      default:  return "none";
    endcase
  endfunction

  task automatic got_event(input int ev);
    int e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event @%0t: got %s, required none", $time, ev_name(ev));
    end else begin
      e = exp_q.pop_front();
      if (e != ev) begin
        bad++;
        $display("FAIL event @%0t: got %s, required %s", $time, ev_name(ev), ev_name(e));
      end else begin
        $display("ok   event @%0t: %s", $time, ev_name(ev));
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      fault_prev = 1'b0;
    end else begin
      if (open_inner && open_outer) both_cnt++;
      if (departing && open_inner)  dep_inner_cnt++;
      if (req_rej)               got_event(EV_REJ);
      if (cycle_done)            got_event(EV_DONE);
      if (fault && !fault_prev)  got_event(EV_FAULT);
      fault_prev = fault;
    end
  end

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s @%0t: got %0d, required %0d", nm, $time, act, req);
    end else begin
      $display("ok   %s @%0t: %0d", nm, $time, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return pump_evac;
      1:       return pump_press;
      2:       return open_inner;
      3:       return open_outer;
      default: return fault;
    endcase
  endfunction

  // Bounded wait; an expired bound is a failed comparison.
  task automatic wait_sig(input string nm, input int w, input logic v, input int lim, output int cnt);
    cnt = 0;
    while ((sig(w) !== v) && (cnt < lim)) begin
      step();
      cnt++;
    end
    total++;
    if (sig(w) !== v) begin
      bad++;
      $display("FAIL %s @%0t: got timeout after %0d cycles, required level %0b", nm, $time, cnt, v);
    end else begin
      $display("ok   %s @%0t: after %0d cycles", nm, $time, cnt);
    end
  endtask

  function automatic int all_outs();
    return {23'd0, arriving, departing, pump_evac, pump_press, open_inner,
            open_outer, req_rej, cycle_done, fault};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    #3;
    check("reset_outs_during_rst", all_outs(), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("reset_outs_after_release", all_outs(), 0);

    // ---------------- departure, nominal ----------------
    depart_req = 1'b1; step(); depart_req = 1'b0;
    check("dep_departing", departing, 1);
    check("dep_arriving", arriving, 0);
    repeat (4) step();
    check("dep_evac_low_wait4", pump_evac, 0);
    step();
    check("dep_evac_rise_wait5", pump_evac, 1);
    pressurized = 1'b0; step();
    evacuated = 1'b1; step();
    check("dep_open_outer", open_outer, 1);
    check("dep_evac_off", pump_evac, 0);
    outer_open = 1'b1; step();
    check("dep_open_outer_drop", open_outer, 0);
    step();
    proceed = 1'b1; step(); proceed = 1'b0;
    outer_open = 1'b0; step();
    check("dep_press", pump_press, 1);
    evacuated = 1'b0; pressurized = 1'b1;
    exp_q.push_back(EV_DONE);
    step();
    check("dep_done_departing", departing, 0);
    check("dep_done_press_off", pump_press, 0);
    step();
    check("dep_done_single", cycle_done, 0);

    // ---------------- arrival, full path ----------------
    arrive_req = 1'b1; step(); arrive_req = 1'b0;
    check("arr_arriving", arriving, 1);
    wait_sig("arr_evac_rise", 0, 1'b1, 10, n);
    check("arr_wait_cycles", n, 3);
    pressurized = 1'b0;
`ifdef AIRLOCK_REQ_QUEUE_EN
    depart_req = 1'b1; step(); depart_req = 1'b0;
    step();
    depart_req = 1'b1; exp_q.push_back(EV_REJ); step(); depart_req = 1'b0;
`else
    depart_req = 1'b1; step(); depart_req = 1'b0;
`endif
    evacuated = 1'b1; step();
    outer_open = 1'b1; step();
    proceed = 1'b1; step(); proceed = 1'b0;
    outer_open = 1'b0; step();
    check("arr_press", pump_press, 1);
    evacuated = 1'b0; pressurized = 1'b1; step();
    check("arr_open_inner", open_inner, 1);
    check("arr_open_outer_low", open_outer, 0);
    check("arr_arriving_open_in", arriving, 1);
    inner_open = 1'b1; step();
    check("arr_open_inner_drop", open_inner, 0);
    proceed = 1'b1; step(); proceed = 1'b0;
    inner_open = 1'b0;
    exp_q.push_back(EV_DONE);
    step();
    check("arr_done_pulse", cycle_done, 1);
    check("arr_arriving_fall", arriving, 0);
    step();
`ifdef AIRLOCK_REQ_QUEUE_EN
    check("queued_dep_start", departing, 1);
    abort = 1'b1; step(); abort = 1'b0;
    check("queued_dep_abort", departing, 0);
`else
    check("busy_req_dropped", departing, 0);
`endif

    // ---------------- simultaneous requests, refusals, abort ----------------
    arrive_req = 1'b1; depart_req = 1'b1; exp_q.push_back(EV_REJ);
    step(); arrive_req = 1'b0; depart_req = 1'b0;
    check("simul_arriving", arriving, 1);
    check("simul_departing", departing, 0);
    abort = 1'b1; step(); abort = 1'b0;
    check("simul_abort", arriving, 0);
    inner_open = 1'b1; depart_req = 1'b1; exp_q.push_back(EV_REJ);
    step(); depart_req = 1'b0; inner_open = 1'b0;
    check("inner_open_rej_idle", departing, 0);
    depart_req = 1'b1; step(); depart_req = 1'b0;
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_wait3_departing", departing, 0);
    check("abort_wait3_evac", pump_evac, 0);
    step(); step();

    // ---------------- EVAC timeout ----------------
    depart_req = 1'b1; step(); depart_req = 1'b0;
    wait_sig("tmo_evac_rise", 0, 1'b1, 10, n);
    repeat (19) step();
    check("tmo_fault_low_19", fault, 0);
    check("tmo_evac_on_19", pump_evac, 1);
    exp_q.push_back(EV_FAULT);
    step();
    check("tmo_fault_20", fault, 1);
    check("tmo_evac_off", pump_evac, 0);
    check("tmo_departing_off", departing, 0);
    depart_req = 1'b1; exp_q.push_back(EV_REJ); step(); depart_req = 1'b0;
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    check("tmo_fault_clr", fault, 0);

    // ---------------- interlock breach ----------------
    depart_req = 1'b1; step(); depart_req = 1'b0;
    wait_sig("ilk_evac_rise", 0, 1'b1, 10, n);
    inner_open = 1'b1; outer_open = 1'b1; exp_q.push_back(EV_FAULT);
    step();
    check("ilk_fault", fault, 1);
    inner_open = 1'b0; outer_open = 1'b0;
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    check("ilk_fault_clr", fault, 0);

    // ---------------- reset mid-PRESS ----------------
    depart_req = 1'b1; step(); depart_req = 1'b0;
    wait_sig("rst_evac_rise", 0, 1'b1, 10, n);
    evacuated = 1'b1; pressurized = 1'b0; step();
    outer_open = 1'b1; step();
    proceed = 1'b1; step(); proceed = 1'b0;
    outer_open = 1'b0; step();
    check("rst_in_press", pump_press, 1);
    rst = 1'b1;
    #1;
    check("rst_async_outs", all_outs(), 0);
    evacuated = 1'b0; pressurized = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_idle_outs", all_outs(), 0);

    // ---------------- wrap-up ----------------
    repeat (3) step();
    check("pending_events", exp_q.size(), 0);
    check("doors_both_cmd", both_cnt, 0);
    check("dep_open_inner", dep_inner_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
